fetch_unit: RTL and testbench

Instruction fetch stage feeding `fetch_decode`: owns the architectural PC, issues word reads to instruction memory over a valid/ready request channel, and absorbs variable memory latency in a small in-order instruction queue. It accepts redirects from execute, the taken-branch/jump path carrying `ALU_out`, and presents `{instr, pc, pc+4}` to decode with a valid/ready handshake. It replaces the free-running PC register and the single fetch flop of the single-cycle datapath for the pipelined design.

---
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the PC, issues credit-limited imem reads and queues responses in order.
// Optional feature macro FETCH_SENTINEL_HALT_EN: halt on the 32'hbadbadff out-of-range memory return.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4,
    output logic        halted
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    localparam logic [1:0]  ST_RUN   = 2'd0;
    localparam logic [1:0]  ST_DRAIN = 2'd1;
    localparam logic [1:0]  ST_HALT  = 2'd2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] count;
    logic [CW-1:0] drop_cnt;

    logic [31:0]   iq_instr [DEPTH];
    logic [31:0]   iq_pc    [DEPTH];
    logic [PW-1:0] iq_wr;
    logic [PW-1:0] iq_rd;
    logic [31:0]   pq_pc    [DEPTH];
    logic [PW-1:0] pq_wr;
    logic [PW-1:0] pq_rd;

    logic          pop;
    logic          redirect_take;
    logic          req_fire;
    logic          discard;
    logic          is_sentinel;
    logic          push;
    logic          go_halt;
    logic [CW:0]   in_use;
    logic [CW-1:0] drop_after;
    logic [31:0]   redirect_target;

    assign dec_valid    = (count != '0);
    assign dec_instr    = iq_instr[iq_rd];
    assign dec_pc       = iq_pc[iq_rd];
    assign dec_pc_plus4 = iq_pc[iq_rd] + 32'd4;

    assign pop             = dec_valid && dec_ready;
    assign redirect_take   = redirect_valid && (state != ST_HALT);
    assign redirect_target = redirect_pc & 32'hffff_fffc;

    // A head popped this cycle frees its slot now, which is what lets DEPTH=2 with L=1 stream one per cycle.
    assign in_use         = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign imem_req_valid = rst_n && (state != ST_HALT) && !redirect_valid && (in_use < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign discard = redirect_take || (state == ST_HALT) ||
                     ((state == ST_DRAIN) && (drop_cnt != '0));

`ifdef FETCH_SENTINEL_HALT_EN
    assign is_sentinel = (imem_resp_data == 32'hbadb_adff);
    assign halted      = (state == ST_HALT);
`else
    assign is_sentinel = 1'b0;
    assign halted      = 1'b0;
`endif

    assign push       = imem_resp_valid && !discard && !is_sentinel;
    assign go_halt    = imem_resp_valid && !discard && is_sentinel;
    assign drop_after = outstanding - CW'(imem_resp_valid);

    // NOTE: the queue storage is reset as well, so the head reads NOP at pc 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                iq_instr[i] <= NOP;
                iq_pc[i]    <= '0;
                pq_pc[i]    <= '0;
            end
        end else begin
            if (push) begin
                iq_instr[iq_wr] <= imem_resp_data;
                iq_pc[iq_wr]    <= pq_pc[pq_rd];
            end
            if (req_fire) begin
                pq_pc[pq_wr] <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            count       <= '0;
            iq_wr       <= '0;
            iq_rd       <= '0;
        end else begin
            if (redirect_take) begin
                fetch_pc <= redirect_target;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (req_fire) begin
                pq_wr <= pq_wr + PW'(1);
            end
            if (imem_resp_valid) begin
                pq_rd <= pq_rd + PW'(1);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);

            // The flush wins over any push or pop in the same cycle.
            if (redirect_take) begin
                count <= '0;
                iq_wr <= '0;
                iq_rd <= '0;
            end else begin
                if (push) begin
                    iq_wr <= iq_wr + PW'(1);
                end
                if (pop) begin
                    iq_rd <= iq_rd + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            drop_cnt <= '0;
        end else if (redirect_take) begin
            drop_cnt <= drop_after;
            state    <= (drop_after != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (go_halt) begin
                        state <= ST_HALT;
                    end
                end
                ST_DRAIN: begin
                    if (go_halt) begin
                        state <= ST_HALT;
                    end else if (imem_resp_valid && (drop_cnt != '0)) begin
                        drop_cnt <= drop_cnt - CW'(1);
                        if (drop_cnt == CW'(1)) begin
                            state <= ST_RUN;
                        end
                    end else if (drop_cnt == '0) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] SENTINEL = 32'hbadb_adff;
`ifdef FETCH_SENTINEL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic        halted;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_pc_plus4    (dec_pc_plus4),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pipe[$];
    exp_t        exp_q[$];
    logic [31:0] pop_pcs[$];
    logic [31:0] pop_instrs[$];
    int          pop_cycs[$];
    logic [31:0] acc_addrs[$];

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          lat;
    int          n_acc;
    int          n_acc_halt;
    bit          halt_m;
    bit          sentinel_on;
    logic [31:0] fetch_pc_m;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (sentinel_on && a == 32'h0100_0008) return SENTINEL;
        return ~a ^ 32'h0000_5a00;
    endfunction

    task automatic clear_logs();
        pop_pcs.delete();
        pop_instrs.delete();
        pop_cycs.delete();
        acc_addrs.delete();
        n_acc      = 0;
        n_acc_halt = 0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        pipe.delete();
        exp_q.delete();
        halt_m     = 1'b0;
        fetch_pc_m = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One clock: score the current cycle mid-way, then advance and drive the memory for the next one.
    task automatic step();
        bit    exp_pop;
        bit    exp_req;
        bit    halt_next;
        int    in_use;
        pend_t p;
        exp_t  e;
        #1;
        n_checks++;
        if (dec_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL dec_valid cyc=%0d: got %b expected %b", cyc, dec_valid, exp_q.size() != 0);
        end
        exp_pop = (exp_q.size() != 0) && dec_ready;
        in_use  = pipe.size() + exp_q.size() - (exp_pop ? 1 : 0);
        exp_req = !halt_m && !redirect_valid && (in_use < DEPTH);
        n_checks++;
        if (imem_req_valid !== exp_req) begin
            n_fail++;
            $display("FAIL imem_req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_req);
        end
        n_checks++;
        if (halted !== halt_m) begin
            n_fail++;
            $display("FAIL halted cyc=%0d: got %b expected %b", cyc, halted, halt_m);
        end

        if (dec_valid === 1'b1 && dec_ready) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (dec_pc !== e.pc || dec_instr !== e.instr || dec_pc_plus4 !== e.pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL dec_head cyc=%0d: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                             cyc, dec_pc, dec_instr, dec_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
                end
            end
            pop_pcs.push_back(dec_pc);
            pop_instrs.push_back(dec_instr);
            pop_cycs.push_back(cyc);
        end

        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            n_checks++;
            if (imem_req_addr !== fetch_pc_m) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, fetch_pc_m);
            end
            p.addr  = fetch_pc_m;
            p.due   = cyc + lat;
            p.stale = 1'b0;
            pipe.push_back(p);
            acc_addrs.push_back(imem_req_addr);
            n_acc++;
            if (halt_m) n_acc_halt++;
            fetch_pc_m = fetch_pc_m + 32'd4;
        end

        halt_next = halt_m;
        if (imem_resp_valid && pipe.size() != 0) begin
            p = pipe.pop_front();
            if (!p.stale && !halt_m && !redirect_valid) begin
                if (HALT_EN && mem_word(p.addr) == SENTINEL) begin
                    halt_next = 1'b1;
                end else begin
                    e.pc    = p.addr;
                    e.instr = mem_word(p.addr);
                    exp_q.push_back(e);
                    n_checks++;
                    if (exp_q.size() > DEPTH) begin
                        n_fail++;
                        $display("FAIL queue_full_at_push cyc=%0d: got %0d entries expected at most %0d",
                                 cyc, exp_q.size(), DEPTH);
                    end
                end
            end
        end

        if (redirect_valid && !halt_m) begin
            exp_q.delete();
            foreach (pipe[i]) pipe[i].stale = 1'b1;
            fetch_pc_m = redirect_pc & 32'hffff_fffc;
        end
        halt_m = halt_next;
        n_checks++;
        if (pipe.size() > DEPTH) begin
            n_fail++;
            $display("FAIL outstanding cyc=%0d: got %0d expected at most %0d", cyc, pipe.size(), DEPTH);
        end

        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (pipe.size() != 0 && pipe[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pipe[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        dec_ready      = 1'b1;
        imem_req_ready = 1'b1;
        rst_n          = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
        do_reset();
        #1;
        n_checks++;
        if (dec_valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got dec_valid=%b halted=%b expected 0 0", dec_valid, halted);
        end
        n_checks++;
        if (dec_instr !== NOP || dec_pc !== 32'h0 || dec_pc_plus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_head: got instr=%h pc=%h pc4=%h expected %h 0 4", dec_instr, dec_pc, dec_pc_plus4, NOP);
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: got valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        run(4);
    endtask

    task automatic test_streaming();
        do_reset();
        lat = 1;
        dec_ready = 1'b1;
        imem_req_ready = 1'b1;
        clear_logs();
        run(8);
        n_checks++;
        if (pop_pcs.size() < 3) begin
            n_fail++;
            $display("FAIL stream_count: got %0d pops expected at least 3", pop_pcs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (pop_pcs[i] !== RESET_PC + 32'(4 * i) || pop_cycs[i] != pop_cycs[0] + i) begin
                    n_fail++;
                    $display("FAIL stream_%0d: got pc=%h cyc=%0d expected pc=%h cyc=%0d",
                             i, pop_pcs[i], pop_cycs[i], RESET_PC + 32'(4 * i), pop_cycs[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        lat = 1;
        dec_ready = 1'b0;
        imem_req_ready = 1'b1;
        clear_logs();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dec_valid === 1'b1 && dec_pc !== RESET_PC) bad++;
        end
        n_checks++;
        if (n_acc != 2) begin
            n_fail++;
            $display("FAIL bp_requests: got %0d expected 2", n_acc);
        end
        n_checks++;
        if (bad != 0 || dec_valid !== 1'b1 || dec_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL bp_head: got moved=%0d valid=%b pc=%h expected 0 1 %h", bad, dec_valid, dec_pc, RESET_PC);
        end
        dec_ready = 1'b1;
        clear_logs();
        run(10);
        n_checks++;
        if (pop_pcs.size() < 4) begin
            n_fail++;
            $display("FAIL bp_release: got %0d pops expected at least 4", pop_pcs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (pop_pcs[i] !== RESET_PC + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d: got %h expected %h", i, pop_pcs[i], RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect_drain();
        int budget;
        do_reset();
        lat = 3;
        dec_ready = 1'b1;
        imem_req_ready = 1'b1;
        clear_logs();
        run(2);
        n_checks++;
        if (n_acc != 2) begin
            n_fail++;
            $display("FAIL drain_setup: got %0d requests expected 2", n_acc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0040;
        clear_logs();
        step();
        budget = 0;
        while (pop_pcs.size() == 0 && budget < 20) begin
            step();
            budget++;
        end
        n_checks++;
        if (pop_pcs.size() == 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got no instruction expected pc 01000040");
        end else if (pop_pcs[0] !== 32'h0100_0040) begin
            n_fail++;
            $display("FAIL drain_target: got %h expected 01000040", pop_pcs[0]);
        end
    endtask

    task automatic test_redirect_pop_resp();
        int budget;
        do_reset();
        lat = 1;
        dec_ready = 1'b1;
        imem_req_ready = 1'b1;
        run(4);
        n_checks++;
        if (imem_resp_valid !== 1'b1 || dec_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rpr_setup: got resp=%b dec_valid=%b expected 1 1", imem_resp_valid, dec_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0083;
        step();
        n_checks++;
        if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rpr_flush: got dec_valid=%b expected 0", dec_valid);
        end
        clear_logs();
        budget = 0;
        while (pop_pcs.size() == 0 && budget < 20) begin
            step();
            budget++;
        end
        n_checks++;
        if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h0100_0080) begin
            n_fail++;
            $display("FAIL rpr_target: got %0d pops first=%h expected 01000080",
                     pop_pcs.size(), (pop_pcs.size() != 0) ? pop_pcs[0] : 32'h0);
        end
    endtask

    task automatic test_sentinel();
        int idx;
        sentinel_on = 1'b1;
        do_reset();
        lat = 1;
        dec_ready = 1'b1;
        imem_req_ready = 1'b1;
        clear_logs();
        run(8);
`ifdef FETCH_SENTINEL_HALT_EN
        n_checks++;
        if (pop_pcs.size() != 2 || pop_pcs[0] !== RESET_PC || pop_pcs[1] !== RESET_PC + 32'd4) begin
            n_fail++;
            $display("FAIL halt_delivered: got %0d pops expected 01000000 then 01000004", pop_pcs.size());
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_flag: got %b expected 1", halted);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0200;
        step();
        run(5);
        n_checks++;
        if (n_acc_halt != 0 || imem_req_valid !== 1'b0 || dec_valid !== 1'b0 || pop_pcs.size() != 2) begin
            n_fail++;
            $display("FAIL halt_quiet: got reqs=%0d req_valid=%b dec_valid=%b pops=%0d expected 0 0 0 2",
                     n_acc_halt, imem_req_valid, dec_valid, pop_pcs.size());
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_sticky: got %b expected 1", halted);
        end
`else
        idx = -1;
        foreach (pop_pcs[i]) if (pop_pcs[i] === 32'h0100_0008 && idx < 0) idx = i;
        n_checks++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL sentinel_data: got no instruction at 01000008 expected %h", SENTINEL);
        end else if (pop_instrs[idx] !== SENTINEL) begin
            n_fail++;
            $display("FAIL sentinel_data: got %h expected %h", pop_instrs[idx], SENTINEL);
        end
        n_checks++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL sentinel_halted: got %b expected 0", halted);
        end
`endif
        sentinel_on = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        lat = 2;
        dec_ready = 1'b1;
        imem_req_ready = 1'b1;
        run(6);
        n_checks++;
        if (dec_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: got dec_valid=%b expected 1", dec_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got dec_valid=%b req_valid=%b expected 0 0", dec_valid, imem_req_valid);
        end
        do_reset();
        clear_logs();
        run(8);
        n_checks++;
        if (acc_addrs.size() == 0 || acc_addrs[0] !== RESET_PC || pop_pcs.size() == 0 || pop_pcs[0] !== RESET_PC) begin
            n_fail++;
            $display("FAIL areset_restart: got %0d reqs %0d pops expected first request and instruction at %h",
                     acc_addrs.size(), pop_pcs.size(), RESET_PC);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = 2;
        clear_logs();
        for (int i = 0; i < 300; i++) begin
            dec_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0100_1000 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            end
            step();
        end
        n_checks++;
        if (pop_pcs.size() < 50) begin
            n_fail++;
            $display("FAIL b2b_progress: got %0d instructions expected at least 50", pop_pcs.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        cyc             = 0;
        lat             = 1;
        sentinel_on     = 1'b0;
        halt_m          = 1'b0;
        fetch_pc_m      = RESET_PC;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        dec_ready       = 1'b1;
        imem_req_ready  = 1'b1;
        rst_n           = 1'b0;
        clear_logs();

        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_drain();
        test_redirect_pop_resp();
        test_sentinel();
        test_async_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
